ws2811_frame_sequencer: RTL

Parametrised frame sequencer between a frame-rate tick source, a pattern ROM and the WS2811 serial transmitter. On each frame it fetches one color per LED unit from the selected pattern, streams the colors to the transmitter over a start/busy handshake, and scrolls the pattern by a programmable step rate in either direction. Pattern selection comes from next/prev command pulses, typically decoded IR commands. Pattern changes take effect only at frame boundaries.

---
 rtl/ws2811_frame_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer: per frame, fetches one color per LED unit from the
// selected ROM pattern and hands each one to the WS2811 transmitter.
// Latency: tick -> ROM address +1, tx data +2, tx start +3 (+1 on data/start with scaling).
// Backpressure: waits on txBusyIN after each start; ticks during a frame are dropped and flagged.
//
// Optional feature macro: BRIGHTNESS_SCALE_EN (adds SCALE state and per-byte brightness multiply).
//
// Ports:
//   clkIN, resetIN            clock, asynchronous active-high reset
//   frameTickIN               frame start pulse
//   patternNextIN/PrevIN      pattern change request pulses
//   reverseIN, stepDivIN      scroll direction and frames-per-step
//   brightnessIN              global brightness (scaling build only)
//   romAddrOUT / romDataIN    pattern ROM, {pattern, color} address, 1-cycle read latency
//   txStartOUT/txDataOUT/txBusyIN  transmitter start/busy handshake
//   frameActiveOUT, overrunOUT, patternIndexOUT  status
module ws2811_frame_sequencer #(
    parameter int UNITS_NUMBER          = 100,
    parameter int PATTERN_COLORS_NUMBER = 128,
    parameter int PATTERNS_NUMBER       = 4,
    parameter int COLOR_WIDTH           = 24,
    parameter int STEP_DIV_WIDTH        = 4,
    localparam int CIW = $clog2(PATTERN_COLORS_NUMBER),
    localparam int PIW = $clog2(PATTERNS_NUMBER),
    localparam int PW  = (PIW > 0) ? PIW : 1,
    localparam int AW  = PIW + CIW
) (
    input  logic                      clkIN,
    input  logic                      resetIN,
    input  logic                      frameTickIN,
    input  logic                      patternNextIN,
    input  logic                      patternPrevIN,
    input  logic                      reverseIN,
    input  logic [STEP_DIV_WIDTH-1:0] stepDivIN,
    input  logic [7:0]                brightnessIN,
    output logic [AW-1:0]             romAddrOUT,
    input  logic [COLOR_WIDTH-1:0]    romDataIN,
    output logic                      txStartOUT,
    output logic [COLOR_WIDTH-1:0]    txDataOUT,
    input  logic                      txBusyIN,
    output logic                      frameActiveOUT,
    output logic                      overrunOUT,
    output logic [PW-1:0]             patternIndexOUT
);
    localparam int UW = (UNITS_NUMBER > 1) ? $clog2(UNITS_NUMBER) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ROMWAIT,
`ifdef BRIGHTNESS_SCALE_EN
        S_SCALE,
`endif
        S_START,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t r_state, w_next;

    logic [PW-1:0]             r_pattern;
    logic [CIW-1:0]            r_offset;
    logic [CIW-1:0]            r_color_idx;
    logic [STEP_DIV_WIDTH-1:0] r_step_cnt;
    logic [UW-1:0]             r_unit;
    logic                      r_pend_vld;
    logic                      r_pend_dir;   // 0 = next, 1 = prev
    logic [COLOR_WIDTH-1:0]    r_data;
    logic                      r_start;
    logic                      r_overrun;

    logic                      w_accept;
    logic                      w_last;
    logic [STEP_DIV_WIDTH-1:0] w_divm1;
    logic                      w_step_hit;
    logic [CIW-1:0]            w_offset_new;
    logic [PW-1:0]             w_pattern_new;
    logic                      w_start_nxt;
    logic                      w_overrun_nxt;
    logic                      w_active;
    logic [COLOR_WIDTH-1:0]    w_tx_data;

    assign w_accept = (r_state == S_IDLE) && frameTickIN;
    assign w_last   = (r_unit == UW'(UNITS_NUMBER - 1));

    // Divider 0 behaves like 1; >= keeps the counter sane if stepDivIN shrinks mid-count.
    assign w_divm1      = (stepDivIN == '0) ? '0 : stepDivIN - 1'b1;
    assign w_step_hit   = (r_step_cnt >= w_divm1);
    assign w_offset_new = !w_step_hit ? r_offset :
                          (reverseIN ? r_offset - 1'b1 : r_offset + 1'b1);

    always_comb begin
        w_pattern_new = r_pattern;
        if (r_pend_vld) begin
            if (r_pend_dir)
                w_pattern_new = (r_pattern == '0) ? PW'(PATTERNS_NUMBER - 1) : r_pattern - 1'b1;
            else
                w_pattern_new = (r_pattern == PW'(PATTERNS_NUMBER - 1)) ? '0 : r_pattern + 1'b1;
        end
    end

`ifdef BRIGHTNESS_SCALE_EN
    logic [COLOR_WIDTH-1:0] w_scaled;
    always_comb begin
        w_scaled = '0;
        for (int b = 0; b < COLOR_WIDTH / 8; b++)
            w_scaled[b*8 +: 8] = 8'((16'(r_data[b*8 +: 8]) * 16'(brightnessIN)) >> 8);
    end
`else
    logic w_unused_bright;
    assign w_unused_bright = ^brightnessIN;
`endif

    // FSM: state register
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (frameTickIN) w_next = S_FETCH;
            S_FETCH:   w_next = S_ROMWAIT;
`ifdef BRIGHTNESS_SCALE_EN
            S_ROMWAIT: w_next = S_SCALE;
            S_SCALE:   w_next = S_START;
`else
            S_ROMWAIT: w_next = S_START;
`endif
            S_START:   w_next = S_HOLD;
            S_HOLD:    w_next = S_WAIT;  // busy may not be up yet, so it is not looked at here
            S_WAIT:    if (!txBusyIN) w_next = w_last ? S_IDLE : S_FETCH;
            default:   w_next = S_IDLE;
        endcase
    end

    // FSM: outputs. Data is passed through while it is being captured so the
    // word is visible one cycle ahead of the start pulse.
    always_comb begin
        w_start_nxt   = (w_next == S_START);
        w_overrun_nxt = frameTickIN && (r_state != S_IDLE);
        w_active      = (r_state != S_IDLE);
`ifdef BRIGHTNESS_SCALE_EN
        w_tx_data     = (r_state == S_SCALE) ? w_scaled : r_data;
`else
        w_tx_data     = (r_state == S_ROMWAIT) ? romDataIN : r_data;
`endif
    end

    // Datapath
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            r_pattern   <= '0;
            r_offset    <= '0;
            r_color_idx <= '0;
            r_step_cnt  <= '0;
            r_unit      <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_dir  <= 1'b0;
            r_data      <= '0;
            r_start     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_start   <= w_start_nxt;
            r_overrun <= w_overrun_nxt;

            // The accepted frame consumes the old request; a request arriving
            // in the same cycle is kept for the following frame.
            if (w_accept) r_pend_vld <= 1'b0;
            if (patternNextIN && patternPrevIN) begin
                r_pend_vld <= 1'b0;
            end else if (patternNextIN) begin
                r_pend_vld <= 1'b1;
                r_pend_dir <= 1'b0;
            end else if (patternPrevIN) begin
                r_pend_vld <= 1'b1;
                r_pend_dir <= 1'b1;
            end

            if (w_accept) begin
                r_pattern   <= w_pattern_new;
                r_offset    <= w_offset_new;
                r_color_idx <= w_offset_new;
                r_unit      <= '0;
                r_step_cnt  <= w_step_hit ? '0 : r_step_cnt + 1'b1;
            end

            if (r_state == S_ROMWAIT) r_data <= romDataIN;
`ifdef BRIGHTNESS_SCALE_EN
            if (r_state == S_SCALE)   r_data <= w_scaled;
`endif

            // Units always walk ascending colors regardless of scroll direction.
            if (r_state == S_WAIT && !txBusyIN && !w_last) begin
                r_unit      <= r_unit + 1'b1;
                r_color_idx <= r_color_idx + 1'b1;
            end
        end
    end

    generate
        if (PIW > 0) begin : g_addr_pat
            assign romAddrOUT = {r_pattern, r_color_idx};
        end else begin : g_addr_nopat
            assign romAddrOUT = r_color_idx;
        end
    endgenerate

    assign patternIndexOUT = r_pattern;
    assign txStartOUT      = r_start;
    assign txDataOUT       = w_tx_data;
    assign overrunOUT      = r_overrun;
    assign frameActiveOUT  = w_active;

endmodule
